// File: rtl/amba3_axi_slave_mem.sv
// AXI3 slave responder backed by a word-addressed internal memory.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding burst each.
module amba3_axi_slave_mem #(
   parameter int                   TXID_SIZE = 4,
   parameter int                   ADDR_SIZE = 32,
   parameter int                   DATA_SIZE = 32,
   parameter int                   MEM_DEPTH = 1024,
   parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic [TXID_SIZE-1:0]   awid,
   input  logic [ADDR_SIZE-1:0]   awaddr,
   input  logic [3:0]             awlen,
   input  logic [2:0]             awsize,
   input  logic [1:0]             awburst,
   input  logic [1:0]             awlock,
   input  logic [3:0]             awcache,
   input  logic [2:0]             awprot,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [TXID_SIZE-1:0]   wid,
   input  logic [DATA_SIZE-1:0]   wdata,
   input  logic [DATA_SIZE/8-1:0] wstrb,
   input  logic                   wlast,
   input  logic                   wvalid,
   output logic                   wready,
   output logic [TXID_SIZE-1:0]   bid,
   output logic [1:0]             bresp,
   output logic                   bvalid,
   input  logic                   bready,
   input  logic [TXID_SIZE-1:0]   arid,
   input  logic [ADDR_SIZE-1:0]   araddr,
   input  logic [3:0]             arlen,
   input  logic [2:0]             arsize,
   input  logic [1:0]             arburst,
   input  logic [1:0]             arlock,
   input  logic [3:0]             arcache,
   input  logic [2:0]             arprot,
   input  logic                   arvalid,
   output logic                   arready,
   output logic [TXID_SIZE-1:0]   rid,
   output logic [DATA_SIZE-1:0]   rdata,
   output logic [1:0]             rresp,
   output logic                   rlast,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [1:0]             w_state_dbg,
   output logic [1:0]             r_state_dbg
);
   localparam int STRB = DATA_SIZE / 8;
   localparam int LG   = $clog2(STRB);
   localparam int IDX  = $clog2(MEM_DEPTH);
   localparam logic [ADDR_SIZE-1:0] ONE = ADDR_SIZE'(1);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

   function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a,
      input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_SIZE-1:0] s, b;
      s = ONE << size;
      b = ADDR_SIZE'({1'b0, len} + 5'd1) * s;
      case (burst)
         2'b01:   next_addr = (a & ~(s - ONE)) + s;
         2'b10:   next_addr = (a & ~(b - ONE)) | ((a + s) & (b - ONE));
         default: next_addr = a;
      endcase
   endfunction

   function automatic logic [ADDR_SIZE-1:0] word_of(input logic [ADDR_SIZE-1:0] a);
      word_of = (a - BASE_ADDR) >> LG;
   endfunction

   // The extra top bit of the subtraction is the borrow, i.e. a < BASE_ADDR.
   function automatic logic out_of_range(input logic [ADDR_SIZE-1:0] a);
      logic [ADDR_SIZE:0] d;
      d = {1'b0, a} - {1'b0, BASE_ADDR};
      out_of_range = d[ADDR_SIZE] || ((d[ADDR_SIZE-1:0] >> LG) >= ADDR_SIZE'(MEM_DEPTH));
   endfunction

   function automatic logic burst_err(input logic [3:0] len, input logic [2:0] size,
      input logic [1:0] burst);
      burst_err = (size > 3'(LG)) || (burst == 2'b11) ||
                  ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
   endfunction

   logic [DATA_SIZE-1:0] mem [MEM_DEPTH];
   logic                 rst_q;

   w_state_t             w_state, w_next;
   logic [TXID_SIZE-1:0] aw_id;
   logic [ADDR_SIZE-1:0] w_addr, w_word;
   logic [3:0]           aw_len, w_cnt;
   logic [2:0]           aw_size;
   logic [1:0]           aw_burst;
   logic                 w_decerr, w_slverr, w_oor, w_end;
   logic                 aw_hs, w_hs, b_hs;
   logic [IDX-1:0]       w_idx;

   r_state_t             r_state, r_next;
   logic [TXID_SIZE-1:0] ar_id;
   logic [ADDR_SIZE-1:0] r_addr, r_nxt, r_fetch, r_word;
   logic [3:0]           ar_len, r_cnt;
   logic [2:0]           ar_size;
   logic [1:0]           ar_burst, rresp_q;
   logic                 r_slverr, r_fetch_oor, r_last_beat;
   logic                 ar_hs, r_hs;
   logic [IDX-1:0]       r_idx;
   logic [DATA_SIZE-1:0] rdata_q;

   logic                 unused_sig;
   assign unused_sig = ^{awlock, awcache, awprot, arlock, arcache, arprot,
                         w_word[ADDR_SIZE-1:IDX], r_word[ADDR_SIZE-1:IDX]};

   // Holds both address readies low for the first cycle after a reset edge.
   always_ff @(posedge aclk) rst_q <= areset;

   assign aw_hs  = awvalid & awready;
   assign w_hs   = wvalid & wready;
   assign b_hs   = bvalid & bready;
   assign w_end  = wlast || (w_cnt == aw_len);
   assign w_oor  = out_of_range(w_addr);
   assign w_word = word_of(w_addr);
   assign w_idx  = w_word[IDX-1:0];

   always_ff @(posedge aclk) begin
      if (areset) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && w_end) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      awready     = (w_state == W_IDLE) && !rst_q;
      wready      = (w_state == W_DATA);
      bvalid      = (w_state == W_RESP);
      bid         = aw_id;
      bresp       = w_decerr ? 2'b11 : (w_slverr ? 2'b10 : 2'b00);
      w_state_dbg = w_state;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_id    <= '0;
         w_addr   <= '0;
         aw_len   <= '0;
         aw_size  <= '0;
         aw_burst <= '0;
         w_cnt    <= '0;
         w_decerr <= 1'b0;
         w_slverr <= 1'b0;
      end else if (aw_hs) begin
         aw_id    <= awid;
         w_addr   <= awaddr;
         aw_len   <= awlen;
         aw_size  <= awsize;
         aw_burst <= awburst;
         w_cnt    <= '0;
         w_decerr <= 1'b0;
         w_slverr <= burst_err(awlen, awsize, awburst);
      end else if (w_hs) begin
         w_addr <= next_addr(w_addr, aw_len, aw_size, aw_burst);
         w_cnt  <= w_cnt + 4'd1;
         if (w_oor) w_decerr <= 1'b1;
         if ((wid != aw_id) || (wlast != (w_cnt == aw_len))) w_slverr <= 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (w_hs && !w_oor && !areset) begin
         for (int i = 0; i < STRB; i++) begin
            if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign ar_hs       = arvalid & arready;
   assign r_hs        = rvalid & rready;
   assign r_last_beat = (r_cnt == ar_len);
   assign r_nxt       = next_addr(r_addr, ar_len, ar_size, ar_burst);
   assign r_fetch     = (r_state == R_ADDR) ? r_addr : r_nxt;
   assign r_fetch_oor = out_of_range(r_fetch);
   assign r_word      = word_of(r_fetch);
   assign r_idx       = r_word[IDX-1:0];

   always_ff @(posedge aclk) begin
      if (areset) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_ADDR;
         R_ADDR:  r_next = R_DATA;
         R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      arready     = (r_state == R_IDLE) && !rst_q;
      rvalid      = (r_state == R_DATA);
      rlast       = (r_state == R_DATA) && r_last_beat;
      rid         = ar_id;
      rdata       = rdata_q;
      rresp       = rresp_q;
      r_state_dbg = r_state;
   end

   // The first beat is fetched in R_ADDR; later beats are fetched on acceptance.
   always_ff @(posedge aclk) begin
      if (areset) begin
         ar_id    <= '0;
         r_addr   <= '0;
         ar_len   <= '0;
         ar_size  <= '0;
         ar_burst <= '0;
         r_cnt    <= '0;
         r_slverr <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= 2'b00;
      end else if (ar_hs) begin
         ar_id    <= arid;
         r_addr   <= araddr;
         ar_len   <= arlen;
         ar_size  <= arsize;
         ar_burst <= arburst;
         r_cnt    <= '0;
         r_slverr <= burst_err(arlen, arsize, arburst);
      end else if ((r_state == R_ADDR) || (r_hs && !r_last_beat)) begin
         rdata_q <= r_fetch_oor ? '0 : mem[r_idx];
         rresp_q <= r_fetch_oor ? 2'b11 : (r_slverr ? 2'b10 : 2'b00);
         if (r_state == R_DATA) begin
            r_addr <= r_nxt;
            r_cnt  <= r_cnt + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_amba3_axi_slave_mem.sv
// Bench for amba3_axi_slave_mem: directed and random AXI3 bursts checked
// against a word-array memory model through B and R expectation queues.
`timescale 1ns/1ps
module tb_amba3_axi_slave_mem;
   localparam int          TXID_SIZE = 4;
   localparam int          ADDR_SIZE = 32;
   localparam int          DATA_SIZE = 32;
   localparam int          MEM_DEPTH = 1024;
   localparam logic [31:0] BASE_ADDR = 32'h0;
   localparam int          RW = TXID_SIZE + 2 + 1 + DATA_SIZE;

   logic        aclk = 1'b0, areset = 1'b1;
   logic [3:0]  awid = '0, wid = '0, arid = '0, bid, rid;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
   logic [3:0]  awlen = '0, arlen = '0, awcache = '0, arcache = '0, wstrb = '0;
   logic [2:0]  awsize = '0, arsize = '0, awprot = '0, arprot = '0;
   logic [1:0]  awburst = '0, arburst = '0, awlock = '0, arlock = '0, bresp, rresp;
   logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
   logic        arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [1:0]  w_state_dbg, r_state_dbg;

   amba3_axi_slave_mem #(.TXID_SIZE(TXID_SIZE), .ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE),
                         .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
      .aclk(aclk), .areset(areset),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg));

   always #5 aclk = ~aclk;

   int checks = 0;
   int failures = 0;
   logic [31:0]   mdl [MEM_DEPTH];
   logic [5:0]    b_exp_q[$];
   logic [RW-1:0] r_exp_q[$];
   logic [31:0]   wd [16];
   logic [3:0]    ws [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      failures++;
      $display("FAIL %s timeout at %0t", name, $time);
   endtask

   function automatic logic [31:0] nxt(input logic [31:0] a, input int len, input int size,
                                       input int burst);
      logic [31:0] s, b;
      s = 32'd1 << size;
      b = 32'(len + 1) * s;
      if (burst == 1) return (a & ~(s - 32'd1)) + s;
      if (burst == 2) return (a & ~(b - 32'd1)) | ((a + s) & (b - 32'd1));
      return a;
   endfunction

   function automatic bit oor(input logic [31:0] a);
      longint d;
      d = longint'(a) - longint'(BASE_ADDR);
      return (d < 0) || ((d >> 2) >= longint'(MEM_DEPTH));
   endfunction

   function automatic bit bad_burst(input int len, input int size, input int burst);
      return (size > 2) || (burst == 3) ||
             (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
   endfunction

   // last_at: beat index driven with wlast=1 (-1 means never).
   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int last_at,
                           input bit bad_wid, input int bdelay);
      logic [31:0] a;
      int nb, n, w;
      bit dec, slv;
      nb  = (last_at >= 0 && last_at <= len) ? last_at + 1 : len + 1;
      slv = bad_burst(len, size, burst) || bad_wid || (last_at != len);
      dec = 1'b0;
      a   = addr;
      for (int k = 0; k < nb; k++) begin
         if (oor(a)) dec = 1'b1;
         else begin
            w = int'((a - BASE_ADDR) >> 2);
            for (int i = 0; i < 4; i++) if (ws[k][i]) mdl[w][8*i +: 8] = wd[k][8*i +: 8];
         end
         a = nxt(a, len, size, burst);
      end
      b_exp_q.push_back({id, dec ? 2'b11 : (slv ? 2'b10 : 2'b00)});

      awvalid = 1'b1; awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size);
      awburst = 2'(burst); awlock = 2'($urandom_range(0, 1)); awcache = 4'($urandom);
      awprot = 3'($urandom);
      n = 0;
      while (1) begin
         @(negedge aclk);
         if (awready) break;
         if (++n > 100) begin tmo("aw_handshake"); break; end
      end
      @(posedge aclk); #1;
      awvalid = 1'b0;
      for (int k = 0; k < nb; k++) begin
         wvalid = 1'b1; wid = (bad_wid && k == 0) ? ~id : id;
         wdata = wd[k]; wstrb = ws[k]; wlast = (k == last_at);
         n = 0;
         while (1) begin
            @(negedge aclk);
            if (wready) break;
            if (++n > 100) begin tmo("w_handshake"); break; end
         end
         @(posedge aclk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      for (int d = 0; d < bdelay; d++) begin
         @(negedge aclk);
         chk("bvalid_hold", bvalid, 1);
         chk("bid_hold", bid, id);
         chk("awready_hold", awready, 0);
         @(posedge aclk); #1;
      end
      bready = 1'b1;
      n = 0;
      while (1) begin
         @(negedge aclk);
         if (bvalid) break;
         if (++n > 100) begin tmo("b_handshake"); break; end
      end
      @(posedge aclk); #1;
      bready = 1'b0;
      chk("awready_after_b", awready, 1);
   endtask

   // rmode: 0 always ready, 1 toggling, 2 random. stop_after limits accepted beats.
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int rmode, input bit chk_lat,
                          input int stop_after);
      logic [31:0] a;
      logic [1:0]  rs;
      int n, got;
      bit tog, slv;
      slv = bad_burst(len, size, burst);
      a   = addr;
      for (int k = 0; k <= len; k++) begin
         rs = oor(a) ? 2'b11 : (slv ? 2'b10 : 2'b00);
         r_exp_q.push_back({id, rs, (k == len) ? 1'b1 : 1'b0,
                            oor(a) ? 32'h0 : mdl[int'((a - BASE_ADDR) >> 2)]});
         a = nxt(a, len, size, burst);
      end

      arvalid = 1'b1; arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size);
      arburst = 2'(burst); arlock = 2'($urandom_range(0, 1)); arcache = 4'($urandom);
      arprot = 3'($urandom);
      n = 0;
      while (1) begin
         @(negedge aclk);
         if (arready) break;
         if (++n > 100) begin tmo("ar_handshake"); break; end
      end
      @(posedge aclk); #1;
      arvalid = 1'b0;
      if (chk_lat) begin
         chk("rvalid_gap", rvalid, 0);
         @(posedge aclk); #1;
         chk("rvalid_latency", rvalid, 1);
      end
      got = 0; n = 0; tog = 1'b1;
      while (got < len + 1 && got < stop_after) begin
         rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
         tog = ~tog;
         @(negedge aclk);
         if (rvalid && rready) got++;
         if (++n > 200) begin tmo("r_beats"); break; end
         @(posedge aclk); #1;
      end
      rready = 1'b0;
      if (got == len + 1) begin
         chk("rvalid_after_last", rvalid, 0);
         chk("rlast_after_last", rlast, 0);
         chk("arready_after_last", arready, 1);
      end
   endtask

   // Monitor: pops at each handshake, peeks while a beat is held by backpressure.
   initial begin
      logic [5:0]    be;
      logic [RW-1:0] re;
      forever begin
         @(negedge aclk);
         if (!areset && bvalid && bready) begin
            if (b_exp_q.size() == 0) tmo("b_unexpected");
            else begin
               be = b_exp_q.pop_front();
               chk("bid", bid, be[5:2]);
               chk("bresp", bresp, be[1:0]);
            end
         end
         if (!areset && rvalid) begin
            if (r_exp_q.size() == 0) tmo("r_unexpected");
            else begin
               re = rready ? r_exp_q.pop_front() : r_exp_q[0];
               chk(rready ? "rid" : "rid_hold", rid, re[RW-1 -: TXID_SIZE]);
               chk(rready ? "rresp" : "rresp_hold", rresp, re[34:33]);
               chk(rready ? "rlast" : "rlast_hold", rlast, re[32]);
               chk(rready ? "rdata" : "rdata_hold", rdata, re[31:0]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      int len, size, burst, last_at;
      logic [31:0] addr;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);   chk("rst_bid", bid, 0);
      chk("rst_bresp", bresp, 0);     chk("rst_arready", arready, 0);
      chk("rst_rvalid", rvalid, 0);   chk("rst_rid", rid, 0);
      chk("rst_rdata", rdata, 0);     chk("rst_rresp", rresp, 0);
      chk("rst_rlast", rlast, 0);
      areset = 1'b0;
      @(posedge aclk); #1;
      chk("post_rst_awready", awready, 1);
      chk("post_rst_arready", arready, 1);

      // Prefill the low region and the top 16 words so every in-range read is defined.
      for (int b = 0; b < 9; b++) begin
         for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
         do_write(4'(b), (b == 8) ? 32'hFC0 : 32'(b * 64), 15, 2, 1, 15, 1'b0, 0);
      end

      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      do_write(4'h3, 32'h10, 0, 2, 1, 0, 1'b0, 0);
      do_read(4'h5, 32'h10, 0, 2, 1, 0, 1'b1, 16);

      for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
      do_write(4'h1, 32'h20, 3, 2, 1, 3, 1'b0, 0);
      wd[0] = 32'hFFFFFFFF; ws[0] = 4'h3;
      do_write(4'h2, 32'h24, 0, 2, 1, 0, 1'b0, 0);
      do_read(4'h6, 32'h20, 3, 2, 1, 0, 1'b0, 16);

      do_read(4'h7, 32'h38, 3, 2, 2, 0, 1'b0, 16);
      do_read(4'h8, 32'h38, 2, 2, 2, 0, 1'b0, 16);

      wd[0] = 32'hA5A5A5A5; ws[0] = 4'h9; wd[1] = 32'h12345678; ws[1] = 4'h6;
      do_write(4'h9, 32'h50, 1, 2, 1, 1, 1'b0, 5);
      do_read(4'hA, 32'h40, 7, 2, 1, 1, 1'b0, 16);

      wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
      do_write(4'hA, 32'h1000, 0, 2, 1, 0, 1'b0, 0);
      do_read(4'hB, 32'h1000, 0, 2, 1, 0, 1'b0, 16);
      do_read(4'hC, 32'h0, 0, 2, 1, 0, 1'b0, 16);

      for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      do_write(4'hD, 32'h60, 3, 2, 1, 1, 1'b0, 0);
      do_write(4'hE, 32'h70, 0, 2, 1, 0, 1'b1, 0);
      do_write(4'hF, 32'h74, 1, 2, 1, -1, 1'b0, 0);
      do_write(4'h1, 32'h78, 0, 2, 3, 0, 1'b0, 0);
      do_read(4'h2, 32'h60, 7, 2, 1, 0, 1'b0, 16);
      do_read(4'h3, 32'h80, 1, 3, 1, 0, 1'b0, 16);

      // Reset while beat 2 of an 8-beat read is on the bus.
      do_read(4'h4, 32'h40, 7, 2, 1, 0, 1'b0, 2);
      areset = 1'b1;
      @(posedge aclk); #1;
      r_exp_q.delete();
      chk("midrst_rvalid", rvalid, 0);  chk("midrst_rlast", rlast, 0);
      chk("midrst_arready", arready, 0); chk("midrst_rdata", rdata, 0);
      areset = 1'b0;
      @(posedge aclk); #1;
      chk("midrst_release_arready", arready, 1);
      do_read(4'h5, 32'h44, 3, 2, 1, 0, 1'b0, 16);

      for (int t = 0; t < 40; t++) begin
         burst = $urandom_range(0, 2);
         size  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
         len   = $urandom_range(0, 15);
         if (burst == 2 && $urandom_range(0, 7) != 0) len = (4 << $urandom_range(0, 2)) - 1;
         if (burst == 2 && $urandom_range(0, 3) == 0) len = 1;
         addr  = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) begin
            burst = 1; size = 2; addr = 32'hFF8 + 32'($urandom_range(0, 1) * 4);
            len = $urandom_range(1, 5);
         end
         if (t % 2 == 0) begin
            for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
            last_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) - 1 : len;
            do_write(4'($urandom), addr, len, size, burst, last_at,
                     ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, $urandom_range(0, 3));
         end else begin
            do_read(4'($urandom), addr, len, size, burst, 2, 1'b0, 16);
         end
      end

      repeat (4) @(posedge aclk);
      chk("b_queue_drained", 64'(b_exp_q.size()), 0);
      chk("r_queue_drained", 64'(r_exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
